// File: rtl/multicycle_control32_if.sv
// Control bus between the multi-cycle sequencer and the MiniSys datapath.
// master = the sequencer (reads IR fields / status, drives enables and selects),
// slave  = the datapath side.
interface multicycle_control32_if;
  // Datapath -> sequencer
  logic [5:0] Opcode;
  logic [5:0] Function_opcode;
  logic       Zero;
  logic       mem_ready;
  // Sequencer -> datapath: per-cycle enables
  logic       PCWrite;
  logic [1:0] PCSrc;
  logic       IRWrite;
  logic       RegWrite;
  logic       MemRead;
  logic       MemWrite;
  // Sequencer -> datapath: static selects
  logic       MemtoReg;
  logic       RegDST;
  logic       ALUSrc;
  logic       Sftmd;
  logic       Jal;
  logic       Jrn;
  logic [1:0] ALUOp;
  // Status / debug
  logic       Retire;
  logic       Illegal;
  logic       MemErr;
  logic [2:0] State;

  modport master (
    input  Opcode, Function_opcode, Zero, mem_ready,
    output PCWrite, PCSrc, IRWrite, RegWrite, MemRead, MemWrite,
           MemtoReg, RegDST, ALUSrc, Sftmd, Jal, Jrn, ALUOp,
           Retire, Illegal, MemErr, State
  );

  modport slave (
    output Opcode, Function_opcode, Zero, mem_ready,
    input  PCWrite, PCSrc, IRWrite, RegWrite, MemRead, MemWrite,
           MemtoReg, RegDST, ALUSrc, Sftmd, Jal, Jrn, ALUOp,
           Retire, Illegal, MemErr, State
  );
endinterface

// File: rtl/multicycle_control32.sv
// Five-state (IF/ID/EX/MEM/WB) multi-cycle sequencer for the MiniSys datapath.
// Decodes Opcode/Function_opcode, issues single-cycle write enables, holds
// MemRead/MemWrite as level requests through MEM and bounds the MEM wait.
module multicycle_control32 #(
  parameter int unsigned MEM_TIMEOUT = 15  // legal 1..255
) (
  input  logic                   clock,
  input  logic                   reset,
  multicycle_control32_if.master bus
);

  localparam logic [2:0] S_IF  = 3'd0;
  localparam logic [2:0] S_ID  = 3'd1;
  localparam logic [2:0] S_EX  = 3'd2;
  localparam logic [2:0] S_MEM = 3'd3;
  localparam logic [2:0] S_WB  = 3'd4;

  localparam logic [5:0] OP_R   = 6'h00;
  localparam logic [5:0] OP_J   = 6'h02;
  localparam logic [5:0] OP_JAL = 6'h03;
  localparam logic [5:0] OP_BEQ = 6'h04;
  localparam logic [5:0] OP_BNE = 6'h05;
  localparam logic [5:0] OP_LW  = 6'h23;
  localparam logic [5:0] OP_SW  = 6'h2B;
  localparam logic [5:0] FN_JR  = 6'h08;

  // Counter value seen in the last allowed MEM cycle (the MEM_TIMEOUT-th one).
  localparam logic [7:0] WAIT_LAST = 8'(MEM_TIMEOUT - 1);

  // Instruction decode
  logic is_r, is_i, is_lw, is_sw, is_beq, is_bne, is_j, is_jal, is_jr, is_shift, is_legal;

  assign is_r     = (bus.Opcode == OP_R);
  assign is_i     = (bus.Opcode[5:3] == 3'b001);
  assign is_lw    = (bus.Opcode == OP_LW);
  assign is_sw    = (bus.Opcode == OP_SW);
  assign is_beq   = (bus.Opcode == OP_BEQ);
  assign is_bne   = (bus.Opcode == OP_BNE);
  assign is_j     = (bus.Opcode == OP_J);
  assign is_jal   = (bus.Opcode == OP_JAL);
  assign is_jr    = is_r & (bus.Function_opcode == FN_JR);
  assign is_shift = is_r & (bus.Function_opcode[5:3] == 3'b000);
  assign is_legal = is_r | is_i | is_lw | is_sw | is_beq | is_bne | is_j | is_jal;

  logic [2:0] state_q, state_d;
  logic [7:0] wait_cnt_q, wait_cnt_d;

  logic       pc_write, ir_write, reg_write, mem_read, mem_write;
  logic       retire, illegal, mem_err;
  logic [1:0] pc_src;

  // Next-state, wait counter and per-cycle enables from state + decode
  always_comb begin
    // NOTE: every signal gets a default before the case so no path leaves it
    // unassigned; otherwise synthesis would infer a latch.
    state_d    = S_IF;
    wait_cnt_d = 8'd0;
    pc_write   = 1'b0;
    pc_src     = 2'b00;
    ir_write   = 1'b0;
    reg_write  = 1'b0;
    mem_read   = 1'b0;
    mem_write  = 1'b0;
    retire     = 1'b0;
    illegal    = 1'b0;
    mem_err    = 1'b0;

    case (state_q)
      S_IF: begin
        ir_write = 1'b1;
        pc_write = 1'b1;
        state_d  = S_ID;
      end
      S_ID: begin
        if (is_j) begin
          pc_write = 1'b1;
          pc_src   = 2'b10;
          retire   = 1'b1;
        end else if (is_jal) begin
          pc_write  = 1'b1;
          pc_src    = 2'b10;
          reg_write = 1'b1;
          retire    = 1'b1;
        end else if (is_jr) begin
          pc_write = 1'b1;
          pc_src   = 2'b11;
          retire   = 1'b1;
        end else if (!is_legal) begin
          illegal = 1'b1;
        end else begin
          state_d = S_EX;
        end
      end
      S_EX: begin
        if (is_beq) begin
          pc_write = bus.Zero;
          pc_src   = 2'b01;
          retire   = 1'b1;
        end else if (is_bne) begin
          pc_write = ~bus.Zero;
          pc_src   = 2'b01;
          retire   = 1'b1;
        end else if (is_lw || is_sw) begin
          state_d = S_MEM;
        end else if (is_r || is_i) begin
          state_d = S_WB;
        end
      end
      S_MEM: begin
        mem_read  = is_lw;
        mem_write = is_sw;
        if (!(is_lw || is_sw)) begin
          state_d = S_IF;
        end else if (bus.mem_ready) begin
          // Completion wins even on the timeout cycle.
          if (is_lw) state_d = S_WB;
          else       retire  = 1'b1;
        end else if (wait_cnt_q == WAIT_LAST) begin
          mem_err = 1'b1;
        end else begin
          state_d    = S_MEM;
          wait_cnt_d = wait_cnt_q + 8'd1;
        end
      end
      S_WB: begin
        reg_write = 1'b1;
        retire    = 1'b1;
      end
      default: ;  // unreachable encodings fall back to IF with no enables
    endcase
  end

  // State and wait-counter registers with synchronous reset
  always_ff @(posedge clock) begin
    // NOTE: sequential state uses non-blocking assignments so every flop
    // samples pre-edge values regardless of statement order.
    if (reset) begin
      state_q    <= S_IF;
      wait_cnt_q <= 8'd0;
    end else begin
      state_q    <= state_d;
      wait_cnt_q <= wait_cnt_d;
    end
  end

  // Static selects are meaningful only once the instruction is latched (ID..WB).
  logic sel_valid;
  assign sel_valid = ~reset & ((state_q == S_ID) | (state_q == S_EX) |
                               (state_q == S_MEM) | (state_q == S_WB));

  assign bus.RegDST   = sel_valid & is_r;
  assign bus.ALUSrc   = sel_valid & (is_i | is_lw | is_sw);
  assign bus.MemtoReg = sel_valid & is_lw;
  assign bus.Sftmd    = sel_valid & is_shift;
  assign bus.Jal      = sel_valid & is_jal;
  assign bus.Jrn      = sel_valid & is_jr;
  assign bus.ALUOp    = sel_valid ? {is_r | is_i, is_beq | is_bne} : 2'b00;

  // Reset forces every output low, including the fetch enables.
  assign bus.PCWrite  = ~reset & pc_write;
  assign bus.PCSrc    = reset ? 2'b00 : pc_src;
  assign bus.IRWrite  = ~reset & ir_write;
  assign bus.RegWrite = ~reset & reg_write;
  assign bus.MemRead  = ~reset & mem_read;
  assign bus.MemWrite = ~reset & mem_write;
  assign bus.Retire   = ~reset & retire;
  assign bus.Illegal  = ~reset & illegal;
  assign bus.MemErr   = ~reset & mem_err;
  assign bus.State    = reset ? 3'd0 : state_q;

endmodule
